pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 17 +
 rtl/Adder_32_Bits.sv | 13 +
 rtl/pc_fetch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants for the instruction fetch stage.
//   - FSM state encoding (FETCH, WAIT, HOLD, ERROR)
//   - default reset PC
//   - counter width used by the hand-off counter
package pc_fetch_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned COUNT_W = 32;

  localparam logic [STATE_W-1:0] ST_FETCH = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;
  localparam logic [STATE_W-1:0] ST_ERROR = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/Adder_32_Bits.sv
// Adder_32_Bits: plain 32-bit unsigned adder, wraps modulo 2^32.
//   Data0  : first operand
//   Data1  : second operand
//   Result : Data0 + Data1 (carry out discarded)
module Adder_32_Bits (
  input  logic [31:0] Data0,
  input  logic [31:0] Data1,
  output logic [31:0] Result
);

  assign Result = Data0 + Data1;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: single-outstanding instruction fetch stage.
// Issues one word request at pc_o, waits for read data, holds the word
// toward decode until accepted, then loads the next PC from PC control.
//
// Ports
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   next_pc_i        : next PC, sampled only on decode hand-off
//   imem_req_o       : memory request valid (FETCH only)
//   imem_addr_o      : memory word address (same as pc_o)
//   imem_ready_i     : memory accepts request
//   imem_rvalid_i    : read data valid (only honoured while waiting)
//   imem_rdata_i     : read data
//   inst_valid_o     : instruction valid toward decode (HOLD only)
//   inst_ready_i     : decode accepts instruction
//   inst_o, pc_o     : held instruction and its PC
//   fetch_count_o    : instructions handed to decode (wraps)
//   misalign_o       : sticky misaligned next-PC error
//
// Build option: FETCH_MISALIGN_CHECK_EN
//   defined   : a misaligned next_pc_i at hand-off is loaded as-is and the
//               stage parks in ERROR until reset.
//   undefined : next_pc_i[1:0] are forced to zero, misalign_o is 0.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N-1:0]       next_pc_i,
  output logic               imem_req_o,
  output logic [N-1:0]       imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [N-1:0]       imem_rdata_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [N-1:0]       inst_o,
  output logic [N-1:0]       pc_o,
  output logic [COUNT_W-1:0] fetch_count_o,
  output logic               misalign_o
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic [N-1:0]       inst_q, inst_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] count_inc;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [N-1:0]       pc_load;
  logic               handoff;

  // Hand-off counter increment through the shared adder.
  Adder_32_Bits u_count_add (
    .Data0  (count_q),
    .Data1  (32'd1),
    .Result (count_inc)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic misaligned;

  assign pc_load    = next_pc_i;
  assign misaligned = |next_pc_i[1:0];
`else
  // Low address bits are dropped so the PC is always word aligned.
  logic unused_pc_low;

  assign pc_load       = {next_pc_i[N-1:2], 2'b00};
  assign unused_pc_low = ^next_pc_i[1:0];
`endif

  assign handoff = (state_q == ST_HOLD) && inst_ready_i;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    count_d = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif

    case (state_q)
      ST_FETCH: begin
        if (imem_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          inst_d  = imem_rdata_i;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handoff) begin
          pc_d    = pc_load;
          count_d = count_inc;
          state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (misaligned) begin
            state_d = ST_ERROR;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Handshake outputs are registered from the next state.
    req_d   = (state_d == ST_FETCH);
    valid_d = (state_d == ST_HOLD);
  end

  // State and datapath registers; reset wins over every other event.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign inst_valid_o  = valid_q;
  assign inst_o        = inst_q;
  assign pc_o          = pc_q;
  assign fetch_count_o = count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_o    = mis_q;
`else
  assign misalign_o    = 1'b0;
`endif

endmodule
